// File: rtl/maxnet_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | maxnet_pkg: shared FSM state encoding and control-word decode.      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package maxnet_pkg;

    localparam int MAX_ITER_DEFAULT     = 64;
    localparam int WAIT_TIMEOUT_DEFAULT = 255;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        WRITE = 3'd4,
        CHECK = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } state_t;

    typedef struct packed {
        logic plu_start;
        logic mux_sel;
        logic we_a_reg;
        logic we_prim;
        logic busy;
        logic done;
        logic error;
    } ctrl_t;

    // Moore output decode; evaluated on the next state so outputs land in the state register's cycle.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c           = '0;
        c.plu_start = (s == START);
        c.mux_sel   = (s == WRITE);
        c.we_a_reg  = (s == LOAD) || (s == WRITE);
        c.we_prim   = (s == LOAD);
        c.busy      = !((s == IDLE) || (s == DONE) || (s == ERR));
        c.done      = (s == DONE);
        c.error     = (s == ERR);
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/maxnet_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | maxnet_controller_if: run request, PLU handshake and datapath ctrl. |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface maxnet_controller_if #(
    parameter int ITER_W = 7
);
    logic              go;
    logic              plu1_done;
    logic              plu2_done;
    logic              plu3_done;
    logic              plu4_done;
    logic              finish;
    logic              plu_start;
    logic              mux_sel;
    logic              we_a_reg;
    logic              we_prim;
    logic              busy;
    logic              done;
    logic              error;
    logic [ITER_W-1:0] iter_cnt;

    modport master (
        input  go, plu1_done, plu2_done, plu3_done, plu4_done, finish,
        output plu_start, mux_sel, we_a_reg, we_prim, busy, done, error, iter_cnt
    );

    modport slave (
        output go, plu1_done, plu2_done, plu3_done, plu4_done, finish,
        input  plu_start, mux_sel, we_a_reg, we_prim, busy, done, error, iter_cnt
    );
endinterface
`default_nettype wire

// File: rtl/maxnet_controller_done_collector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | done_collector: sticky capture of the four PLU done strobes.        |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module done_collector (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       clear,
    input  wire logic       enable,
    input  wire logic [3:0] done_in,
    output logic            all_done
);
    logic [3:0] r_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= '0;
        end else if (clear) begin
            r_sticky <= '0;
        end else if (enable) begin
            r_sticky <= r_sticky | done_in;
        end
    end

    // Live inputs are OR'ed in so a final done arriving this cycle completes the set.
    assign all_done = &(r_sticky | done_in);

endmodule
`default_nettype wire

// File: rtl/maxnet_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | maxnet_controller: sequences load / PLU iterate / write-back / check.|
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module maxnet_controller
    import maxnet_pkg::*;
#(
    parameter int MAX_ITER     = MAX_ITER_DEFAULT,
    parameter int ITER_W       = 7,
    parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEFAULT,
    parameter int TO_W         = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    maxnet_controller_if.master bus
);
    localparam logic [ITER_W-1:0] C_ITER_LIMIT = ITER_W'(MAX_ITER);
    localparam logic [TO_W-1:0]   C_WD_LAST    = TO_W'(WAIT_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next;
    ctrl_t             r_ctrl;
    logic [ITER_W-1:0] r_iter_cnt;
    logic [TO_W-1:0]   r_watchdog;
    logic              w_all_done;

    done_collector u_done_collector (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (r_state == START),
        .enable   (r_state == WAIT),
        .done_in  ({bus.plu4_done, bus.plu3_done, bus.plu2_done, bus.plu1_done}),
        .all_done (w_all_done)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.go) w_next = LOAD;
            LOAD:    w_next = START;
            START:   w_next = WAIT;
            WAIT: begin
                // Completion beats the watchdog when both land together.
                if (w_all_done)                   w_next = WRITE;
                else if (r_watchdog == C_WD_LAST) w_next = ERR;
            end
            WRITE:   w_next = CHECK;
            CHECK: begin
                if (bus.finish)                       w_next = DONE;
                else if (r_iter_cnt == C_ITER_LIMIT)  w_next = ERR;
                else                                  w_next = START;
            end
            DONE:    if (!bus.go) w_next = IDLE;
            ERR:     if (!bus.go) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ctrl     <= '0;
            r_iter_cnt <= '0;
            r_watchdog <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= decode_ctrl(w_next);
            case (r_state)
                LOAD:  r_iter_cnt <= '0;
                WRITE: if (r_iter_cnt != C_ITER_LIMIT) r_iter_cnt <= r_iter_cnt + ITER_W'(1);
                START: r_watchdog <= '0;
                WAIT:  r_watchdog <= r_watchdog + TO_W'(1);
                default: ;
            endcase
        end
    end

    assign bus.plu_start = r_ctrl.plu_start;
    assign bus.mux_sel   = r_ctrl.mux_sel;
    assign bus.we_a_reg  = r_ctrl.we_a_reg;
    assign bus.we_prim   = r_ctrl.we_prim;
    assign bus.busy      = r_ctrl.busy;
    assign bus.done      = r_ctrl.done;
    assign bus.error     = r_ctrl.error;
    assign bus.iter_cnt  = r_iter_cnt;

endmodule
`default_nettype wire

// File: doc/maxnet_controller.md
Name: maxnet_controller

Overview:
- Control FSM that sequences a Maxnet datapath.
- Initiator side of the PLU start/done handshake: the four PLUs respond to `plu_start` with `pluN_done`.
- Loads initial activations, issues one start per iteration, waits for all four dones, writes results back, then samples the output-check `finish`.
- Iterates until a winner is found, or until an iteration or timeout limit is hit.

Parameters:
- MAX_ITER, 64, iteration limit; reaching it without `finish` raises `error`.
- ITER_W, 7, width of `iter_cnt`; must hold MAX_ITER.
- WAIT_TIMEOUT, 255, max cycles in WAIT per iteration before `error`.
- TO_W, 8, width of the watchdog counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- go  in  1  request a run; level, sampled in IDLE.
- plu1_done  in  1  PLU1 done; pulse or level.
- plu2_done  in  1  PLU2 done; pulse or level.
- plu3_done  in  1  PLU3 done; pulse or level.
- plu4_done  in  1  PLU4 done; pulse or level.
- finish  in  1  output-check valid (single winner found).
- plu_start  out  1  one-cycle start to all PLUs.
- mux_sel  out  1  0 = init values to activation regs; 1 = PLU results.
- we_a_reg  out  1  activation register write enable.
- we_prim  out  1  original-value register write enable.
- busy  out  1  high in every state except IDLE/DONE/ERR.
- done  out  1  run completed with winner.
- error  out  1  run aborted (MAX_ITER or timeout).
- iter_cnt  out  ITER_W  completed iterations.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; done-sticky bits 0; iter_cnt=0; watchdog=0.
- Outputs are decoded from registered state (Moore); no combinational input-to-output path.
- IDLE: if go=1 at an edge -> LOAD.
- LOAD (1 cycle): mux_sel=0, we_a_reg=1, we_prim=1; iter_cnt<=0 -> START.
- START (1 cycle): plu_start=1; clear sticky bits and watchdog -> WAIT. Done inputs during START are ignored.
- WAIT:
  - Sticky bit k <= k | pluk_done each cycle.
  - Watchdog increments each cycle.
  - Test `all_done` = (sticky OR current inputs) == 4'b1111, so a final done arriving this cycle counts.
  - If all_done -> WRITE.
  - Else if watchdog == WAIT_TIMEOUT-1 -> ERR.
  - all_done wins over timeout in the same cycle.
- WRITE (1 cycle): mux_sel=1, we_a_reg=1; iter_cnt<=iter_cnt+1 -> CHECK.
- CHECK (1 cycle): sample finish.
  - finish=1 -> DONE.
  - Else iter_cnt==MAX_ITER -> ERR.
  - Else -> START.
  - finish has priority over the limit.
- DONE: done=1, iter_cnt held; stay until go=0, then IDLE.
- ERR: error=1, iter_cnt held; stay until go=0, then IDLE.
- Ignored inputs:
  - go while busy: no effect.
  - pluN_done outside WAIT: no effect.
  - finish outside CHECK: no effect.
- Latency: go sampled at edge k -> LOAD in cycle k+1 -> plu_start high in cycle k+2. Fixed overhead per iteration is START + WRITE + CHECK = 3 cycles plus the PLU time.
- iter_cnt never exceeds MAX_ITER; no wrap.
- Reset mid-run: outputs drop asynchronously; a new run restarts from LOAD.

Decomposition:
- Package `maxnet_pkg`: state enum (IDLE, LOAD, START, WAIT, WRITE, CHECK, DONE, ERR) and default MAX_ITER/WAIT_TIMEOUT constants shared with the datapath bench.
- One natural sub-module, `done_collector`: four sticky bits, clear on START, all_done output.
- Watchdog and iteration counter stay inline.

Test Plan:
- Single iteration: go=1; all dones 3 cycles after plu_start; finish=1 in CHECK.
  -> plu_start exactly once; we_prim only in LOAD; done=1; iter_cnt=1.
- Staggered dones: one-cycle pulses at +2, +5, +5, +9 after start.
  -> WRITE in the cycle after the +9 pulse; no early WRITE; iter_cnt increments.
- Multi-round: finish=0 for 2 CHECKs, 1 on the third.
  -> 3 plu_start pulses; mux_sel=1 in each WRITE; done=1, iter_cnt=3.
- Iteration limit: MAX_ITER=4, finish never asserted.
  -> error=1 after the 4th CHECK, iter_cnt=4, no 5th plu_start.
- Timeout: WAIT_TIMEOUT=10, plu3_done never asserted.
  -> ERR entered 10 cycles after entering WAIT; error=1, busy=0.
- Reset and go handling:
  -> rst_n=0 mid-WAIT: all outputs 0 immediately; after release, go=1 gives LOAD again.
  -> go toggled during WAIT: no effect.
  -> In DONE with go held high: done stays 1 until go=0.
